// File: rtl/adder_operand_sequencer_if.sv
// Operand/issue bundle between the A/B producers, the sequencer and the adder stage.
// OPERAND_PAIR_CNT_EN adds the pair_cnt observation output.
interface adder_operand_sequencer_if #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             a_in_valid;
  logic             a_in_ready;
  logic [WIDTH-1:0] a_in_data;
  logic             b_in_valid;
  logic             b_in_ready;
  logic [WIDTH-1:0] b_in_data;
  logic             flush;
  logic             issue_ready;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             issue_valid;
  logic             res_valid;
  logic [CW-1:0]    a_count;
  logic [CW-1:0]    b_count;
`ifdef OPERAND_PAIR_CNT_EN
  logic [15:0]      pair_cnt;
`endif

  // Producer/consumer side: drives operands and control, observes status
  modport master (
    output a_in_valid, a_in_data, b_in_valid, b_in_data, flush, issue_ready,
    input  a_in_ready, b_in_ready, a_out, b_out, issue_valid, res_valid,
`ifdef OPERAND_PAIR_CNT_EN
    input  pair_cnt,
`endif
    input  a_count, b_count
  );

  // Sequencer side
  modport slave (
    input  a_in_valid, a_in_data, b_in_valid, b_in_data, flush, issue_ready,
    output a_in_ready, b_in_ready, a_out, b_out, issue_valid, res_valid,
`ifdef OPERAND_PAIR_CNT_EN
    output pair_cnt,
`endif
    output a_count, b_count
  );
endinterface

// File: rtl/adder_operand_sequencer.sv
// Buffers A and B operand streams in two FIFOs and issues matched pairs to the
// registered adder; res_valid tracks the adder's one-cycle sum latency.
// OPERAND_PAIR_CNT_EN adds a 16-bit wrapping count of issued pairs.
module adder_operand_sequencer #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  adder_operand_sequencer_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] a_mem_q [DEPTH];
  logic [WIDTH-1:0] a_mem_d [DEPTH];
  logic [WIDTH-1:0] b_mem_q [DEPTH];
  logic [WIDTH-1:0] b_mem_d [DEPTH];
  logic [PW-1:0]    a_wptr_q, a_wptr_d, a_rptr_q, a_rptr_d;
  logic [PW-1:0]    b_wptr_q, b_wptr_d, b_rptr_q, b_rptr_d;
  logic [CW-1:0]    a_count_q, a_count_d, b_count_q, b_count_d;
  logic [WIDTH-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic             issue_valid_q, issue_valid_d;
  logic             res_valid_q, res_valid_d;
  logic             a_ready, b_ready, a_push, b_push, pop;
`ifdef OPERAND_PAIR_CNT_EN
  logic [15:0]      pair_cnt_q, pair_cnt_d;
`endif

  // Ready depends on occupancy only, so a full FIFO refuses even if it pops this cycle
  assign a_ready = (a_count_q != CW'(DEPTH));
  assign b_ready = (b_count_q != CW'(DEPTH));

  // FIFO bookkeeping, pair issue and result-valid pipeline
  always_comb begin
    a_push        = bus.a_in_valid && a_ready && !bus.flush;
    b_push        = bus.b_in_valid && b_ready && !bus.flush;
    pop           = (a_count_q != '0) && (b_count_q != '0) && bus.issue_ready && !bus.flush;
    a_mem_d       = a_mem_q;
    b_mem_d       = b_mem_q;
    a_wptr_d      = a_wptr_q;
    a_rptr_d      = a_rptr_q;
    b_wptr_d      = b_wptr_q;
    b_rptr_d      = b_rptr_q;
    a_count_d     = a_count_q;
    b_count_d     = b_count_q;
    a_out_d       = a_out_q;
    b_out_d       = b_out_q;
    issue_valid_d = pop;
    res_valid_d   = issue_valid_q;
`ifdef OPERAND_PAIR_CNT_EN
    pair_cnt_d    = pop ? pair_cnt_q + 16'd1 : pair_cnt_q;
`endif
    if (bus.flush) begin
      a_wptr_d  = '0;
      a_rptr_d  = '0;
      b_wptr_d  = '0;
      b_rptr_d  = '0;
      a_count_d = '0;
      b_count_d = '0;
    end else begin
      if (a_push) begin
        a_mem_d[a_wptr_q] = bus.a_in_data;
        a_wptr_d          = a_wptr_q + PW'(1);
      end
      if (b_push) begin
        b_mem_d[b_wptr_q] = bus.b_in_data;
        b_wptr_d          = b_wptr_q + PW'(1);
      end
      if (pop) begin
        a_out_d  = a_mem_q[a_rptr_q];
        b_out_d  = b_mem_q[b_rptr_q];
        a_rptr_d = a_rptr_q + PW'(1);
        b_rptr_d = b_rptr_q + PW'(1);
      end
      case ({a_push, pop})
        2'b10:   a_count_d = a_count_q + CW'(1);
        2'b01:   a_count_d = a_count_q - CW'(1);
        default: a_count_d = a_count_q;
      endcase
      case ({b_push, pop})
        2'b10:   b_count_d = b_count_q + CW'(1);
        2'b01:   b_count_d = b_count_q - CW'(1);
        default: b_count_d = b_count_q;
      endcase
    end
  end

  // State registers; reset discards buffered operands and in-flight valids
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mem_q       <= '{default: '0};
      b_mem_q       <= '{default: '0};
      a_wptr_q      <= '0;
      a_rptr_q      <= '0;
      b_wptr_q      <= '0;
      b_rptr_q      <= '0;
      a_count_q     <= '0;
      b_count_q     <= '0;
      a_out_q       <= '0;
      b_out_q       <= '0;
      issue_valid_q <= 1'b0;
      res_valid_q   <= 1'b0;
`ifdef OPERAND_PAIR_CNT_EN
      pair_cnt_q    <= '0;
`endif
    end else begin
      a_mem_q       <= a_mem_d;
      b_mem_q       <= b_mem_d;
      a_wptr_q      <= a_wptr_d;
      a_rptr_q      <= a_rptr_d;
      b_wptr_q      <= b_wptr_d;
      b_rptr_q      <= b_rptr_d;
      a_count_q     <= a_count_d;
      b_count_q     <= b_count_d;
      a_out_q       <= a_out_d;
      b_out_q       <= b_out_d;
      issue_valid_q <= issue_valid_d;
      res_valid_q   <= res_valid_d;
`ifdef OPERAND_PAIR_CNT_EN
      pair_cnt_q    <= pair_cnt_d;
`endif
    end
  end

  assign bus.a_in_ready  = a_ready;
  assign bus.b_in_ready  = b_ready;
  assign bus.a_out       = a_out_q;
  assign bus.b_out       = b_out_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.a_count     = a_count_q;
  assign bus.b_count     = b_count_q;
`ifdef OPERAND_PAIR_CNT_EN
  assign bus.pair_cnt    = pair_cnt_q;
`endif
endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed, table-driven bench for adder_operand_sequencer with a registered adder model.
module tb_adder_operand_sequencer;
  localparam int unsigned WIDTH = 10;
  localparam int unsigned DEPTH = 4;
  localparam int NV = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [WIDTH:0] sum_q;
  int n_pass = 0;
  int n_total = 0;

  adder_operand_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  adder_operand_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Downstream registered adder stage
  always @(posedge clk) sum_q <= {1'b0, bus.a_out} + {1'b0, bus.b_out};

  typedef struct {
    logic       av;
    logic [9:0] ad;
    logic       bv;
    logic [9:0] bd;
    logic       fl;
    logic       ir;
    logic       iv;
    logic       rv;
    logic [9:0] ea;
    logic [9:0] eb;
    int         ac;
    int         bc;
    int         sum;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic av, input int ad, input logic bv, input int bd,
                              input logic fl, input logic ir, input logic iv, input logic rv,
                              input int ea, input int eb, input int ac, input int bc, input int sum);
    vec_t v;
    v.av = av; v.ad = 10'(ad); v.bv = bv; v.bd = 10'(bd); v.fl = fl; v.ir = ir;
    v.iv = iv; v.rv = rv; v.ea = 10'(ea); v.eb = 10'(eb); v.ac = ac; v.bc = bc; v.sum = sum;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic av, input int ad, input logic bv, input int bd,
                       input logic fl, input logic ir);
    bus.a_in_valid  = av;
    bus.a_in_data   = 10'(ad);
    bus.b_in_valid  = bv;
    bus.b_in_data   = 10'(bd);
    bus.flush       = fl;
    bus.issue_ready = ir;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int iv, input int rv, input int ea,
                            input int eb, input int ac, input int bc);
    check({tag, " issue_valid"}, int'(bus.issue_valid), iv);
    check({tag, " res_valid"}, int'(bus.res_valid), rv);
    check({tag, " a_out"}, int'(bus.a_out), ea);
    check({tag, " b_out"}, int'(bus.b_out), eb);
    check({tag, " a_count"}, int'(bus.a_count), ac);
    check({tag, " b_count"}, int'(bus.b_count), bc);
    check({tag, " a_in_ready"}, int'(bus.a_in_ready), (ac != DEPTH) ? 1 : 0);
    check({tag, " b_in_ready"}, int'(bus.b_in_ready), (bc != DEPTH) ? 1 : 0);
  endtask

  initial begin
    // av ad bv bd fl ir | iv rv a b ac bc sum
    tbl[0]  = mk(1, 3, 1, 5, 0, 1,   0, 0, 0, 0, 1, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 1,   1, 0, 3, 5, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1,   0, 1, 3, 5, 0, 0, 8);
    tbl[3]  = mk(1, 1, 0, 0, 0, 1,   0, 0, 3, 5, 1, 0, 0);
    tbl[4]  = mk(1, 2, 0, 0, 0, 1,   0, 0, 3, 5, 2, 0, 0);
    tbl[5]  = mk(1, 3, 0, 0, 0, 1,   0, 0, 3, 5, 3, 0, 0);
    tbl[6]  = mk(1, 4, 0, 0, 0, 1,   0, 0, 3, 5, 4, 0, 0);
    tbl[7]  = mk(1, 5, 0, 0, 0, 1,   0, 0, 3, 5, 4, 0, 0);
    tbl[8]  = mk(0, 0, 1, 10, 0, 1,  0, 0, 3, 5, 4, 1, 0);
    tbl[9]  = mk(0, 0, 1, 20, 0, 1,  1, 0, 1, 10, 3, 1, 0);
    tbl[10] = mk(0, 0, 1, 30, 0, 1,  1, 1, 2, 20, 2, 1, 11);
    tbl[11] = mk(0, 0, 1, 40, 0, 1,  1, 1, 3, 30, 1, 1, 22);
    tbl[12] = mk(0, 0, 0, 0, 0, 1,   1, 1, 4, 40, 0, 0, 33);
    tbl[13] = mk(0, 0, 0, 0, 0, 1,   0, 1, 4, 40, 0, 0, 44);
    tbl[14] = mk(0, 0, 0, 0, 0, 1,   0, 0, 4, 40, 0, 0, 0);
    tbl[15] = mk(1, 11, 1, 21, 0, 0, 0, 0, 4, 40, 1, 1, 0);
    tbl[16] = mk(1, 12, 1, 22, 0, 0, 0, 0, 4, 40, 2, 2, 0);
    tbl[17] = mk(1, 13, 1, 23, 0, 0, 0, 0, 4, 40, 3, 3, 0);
    tbl[18] = mk(1, 14, 1, 24, 0, 0, 0, 0, 4, 40, 4, 4, 0);
    tbl[19] = mk(1, 99, 1, 99, 0, 0, 0, 0, 4, 40, 4, 4, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0,   0, 0, 4, 40, 4, 4, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0,   0, 0, 4, 40, 4, 4, 0);
    tbl[22] = mk(0, 0, 0, 0, 0, 1,   1, 0, 11, 21, 3, 3, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 1,   1, 1, 12, 22, 2, 2, 32);
    tbl[24] = mk(0, 0, 0, 0, 0, 1,   1, 1, 13, 23, 1, 1, 34);
    tbl[25] = mk(0, 0, 0, 0, 0, 1,   1, 1, 14, 24, 0, 0, 36);
    tbl[26] = mk(0, 0, 0, 0, 0, 1,   0, 1, 14, 24, 0, 0, 38);
    tbl[27] = mk(1, 7, 1, 9, 0, 0,   0, 0, 14, 24, 1, 1, 0);
    tbl[28] = mk(1, 8, 1, 10, 0, 0,  0, 0, 14, 24, 2, 2, 0);
    tbl[29] = mk(1, 6, 1, 6, 0, 1,   1, 0, 7, 9, 2, 2, 0);
    tbl[30] = mk(1, 50, 1, 60, 1, 1, 0, 1, 7, 9, 0, 0, 16);
    tbl[31] = mk(0, 0, 0, 0, 0, 1,   0, 0, 7, 9, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0);
    repeat (2) step();
    check_outs("reset", 0, 0, 0, 0, 0, 0);
`ifdef OPERAND_PAIR_CNT_EN
    check("reset pair_cnt", int'(bus.pair_cnt), 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].av, int'(tbl[i].ad), tbl[i].bv, int'(tbl[i].bd), tbl[i].fl, tbl[i].ir);
      step();
      check_outs($sformatf("vec%0d", i), int'(tbl[i].iv), int'(tbl[i].rv),
                 int'(tbl[i].ea), int'(tbl[i].eb), tbl[i].ac, tbl[i].bc);
      if (tbl[i].rv) check($sformatf("vec%0d sum", i), int'(sum_q), tbl[i].sum);
    end
`ifdef OPERAND_PAIR_CNT_EN
    check("pair_cnt after table", int'(bus.pair_cnt), 10);
`endif

    // Reset while a result is pending and both FIFOs hold data
    drive(1, 100, 1, 200, 0, 0);
    step();
    drive(1, 101, 1, 201, 0, 1);
    step();
    check_outs("pre-rst", 1, 0, 100, 200, 1, 1);
    drive(0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    #1;
    check_outs("async rst", 0, 0, 0, 0, 0, 0);
`ifdef OPERAND_PAIR_CNT_EN
    check("rst pair_cnt", int'(bus.pair_cnt), 0);
`endif
    step();
    rst = 1'b0;
    step();
    check_outs("post-rst1", 0, 0, 0, 0, 0, 0);
    step();
    check_outs("post-rst2", 0, 0, 0, 0, 0, 0);

    // Three back-to-back pairs, then flush must leave the pair count alone
    drive(1, 1, 1, 2, 0, 1);
    step();
    check_outs("p3 c0", 0, 0, 0, 0, 1, 1);
    drive(1, 3, 1, 4, 0, 1);
    step();
    check_outs("p3 c1", 1, 0, 1, 2, 1, 1);
    drive(1, 5, 1, 6, 0, 1);
    step();
    check_outs("p3 c2", 1, 1, 3, 4, 1, 1);
    check("p3 sum", int'(sum_q), 3);
    drive(0, 0, 0, 0, 0, 1);
    step();
    check_outs("p3 c3", 1, 1, 5, 6, 0, 0);
    step();
    check_outs("p3 c4", 0, 1, 5, 6, 0, 0);
    check("p3 last sum", int'(sum_q), 11);
`ifdef OPERAND_PAIR_CNT_EN
    check("pair_cnt three", int'(bus.pair_cnt), 3);
`endif
    drive(1, 9, 1, 9, 1, 1);
    step();
    check_outs("flush2", 0, 0, 5, 6, 0, 0);
`ifdef OPERAND_PAIR_CNT_EN
    check("pair_cnt after flush", int'(bus.pair_cnt), 3);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("pair_cnt cleared", int'(bus.pair_cnt), 0);
    step();
    rst = 1'b0;
`endif
    drive(0, 0, 0, 0, 0, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/adder_operand_sequencer.md
Name: adder_operand_sequencer

Overview:
- Upstream feeder for the team's registered 10-bit adder stage.
- Buffers the A and B operand streams independently, each behind a valid/ready handshake.
- When both streams hold data and the consumer can accept, pops one pair and presents it as registered a_out/b_out.
- Emits res_valid aligned with the adder's one-cycle registered sum, so downstream logic knows exactly when sum is meaningful.

Parameters:
WIDTH, 10, operand width; matches the adder's `WIDTH.
DEPTH, 4, entries per operand FIFO; power of two, >= 2.
CW, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
a_in_valid  input  1  A operand offered
a_in_ready  output  1  A FIFO can accept
a_in_data  input  WIDTH  A operand
b_in_valid  input  1  B operand offered
b_in_ready  output  1  B FIFO can accept
b_in_data  input  WIDTH  B operand
flush  input  1  synchronous clear of both FIFOs
issue_ready  input  1  consumer accepts a pair this cycle
a_out  output  WIDTH  registered A operand, to adder a
b_out  output  WIDTH  registered B operand, to adder b
issue_valid  output  1  a_out/b_out hold a newly issued pair this cycle
res_valid  output  1  adder sum valid this cycle (issue_valid delayed 1)
a_count  output  CW  A FIFO occupancy
b_count  output  CW  B FIFO occupancy

Behaviour:
- Reset (async, rst=1): both FIFOs empty, pointers 0, counts 0, a_out=b_out=0, issue_valid=0, res_valid=0.
- A reset asserted mid-operation discards all buffered operands and any in-flight res_valid.
- Ready: a_in_ready = (a_count != DEPTH); b_in_ready likewise; combinational from count only, never from a same-cycle pop.
- Push: entry written when valid && ready; data held in FIFO order. valid while not ready is ignored, with no side effect.
- Pop condition: pop = (a_count != 0) && (b_count != 0) && issue_ready && !flush.
  - Both FIFOs pop together; never one without the other.
- Issue register, at the edge where pop=1:
  - a_out <= A head; b_out <= B head; issue_valid <= 1.
  - Otherwise issue_valid <= 0, and a_out/b_out hold their last values.
- Latency:
  - Earliest issue_valid is 2 cycles after a push into an empty FIFO (push edge, then pop edge).
  - res_valid is issue_valid registered once, which matches the adder's sum latency.
- Simultaneous push and pop on the same FIFO: count is unchanged, and both the write and the read occur.
  - When full, the push is refused because ready was already low.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; count tracks fullness unambiguously.
- Flush:
  - Next edge: counts and pointers go to 0; pushes that cycle are dropped.
  - No pop that cycle.
  - issue_valid and res_valid already in flight complete normally.
- Throughput: one pair per cycle sustained when both streams keep FIFOs non-empty and issue_ready=1.
- Arithmetic: the block does no arithmetic; operands pass bit-exact.

Optional Feature:
Macro: OPERAND_PAIR_CNT_EN.
- Defined:
  - Adds output pair_cnt [15:0], counting issued pairs; increments on each edge where pop=1.
  - Wraps 0xFFFF -> 0x0000.
  - Reset to 0 by rst; unaffected by flush.
- Undefined: no pair_cnt port and no counter logic; all other behaviour identical.

Test Plan:
- Reset, then push A=3 and B=5 in the same cycle with issue_ready=1 -> issue_valid 2 cycles later with a_out=3, b_out=5; res_valid the following cycle; adder sum=8.
- Push A=1,2,3,4,5 with no B and issue_ready=1 -> a_count reaches 4 and a_in_ready=0; A=5 is refused; no issue_valid.
- Then push B=10,20,30,40 -> pairs issue in order (1,10) (2,20) (3,30) (4,40), one per cycle; counts return to 0.
- Fill both FIFOs, hold issue_ready=0 for 3 cycles, then 1 -> no issue while low; then 4 back-to-back issues; pointers wrap correctly on the next fill.
- Issue pair (7,9), then assert flush the next cycle while A/B still hold entries -> res_valid still pulses for (7,9); counts 0 after the flush; pushes during flush are dropped.
- Assert rst for 1 cycle with res_valid pending and FIFOs partially full -> all outputs 0 immediately; no res_valid after release.
- With OPERAND_PAIR_CNT_EN defined: issue 3 pairs -> pair_cnt=3; flush leaves it at 3; rst clears it to 0.
